// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel/gradient widths, window types and default frame geometry
// for the Sobel path (WIDTH default doubles as the line-buffer DEPTH).
package sobel_pkg;
    localparam int PIX_W = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_MAX = 255;
    localparam int DEF_WIDTH = 640;
    localparam int DEF_HEIGHT = 480;
    typedef logic [PIX_W-1:0] pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef pix_t [2:0][2:0] win_t;
    // The centre pixel carries zero weight in both Sobel kernels, so it is not passed on.
    typedef struct packed {
        pix_t [2:0] r0;
        pix_t [2:0] r2;
        pix_t r1_c0;
        pix_t r1_c2;
    } nbr_t;
    function automatic grad_t widen(input pix_t p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction
endpackage

// File: rtl/sobel_kernel.sv
// sobel_kernel: two-stage Gx/Gy -> |Gx|+|Gy| pipeline with its valid/last pipe.
// SOBEL_THRESH_EN switches the stage-2 output to a binarised THRESH compare.
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int THRESH = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic win_valid,
    input  logic win_last,
    input  nbr_t nbr,
    output pix_t mag,
    output logic valid,
    output logic frame_done
);
    grad_t gx, gy, gx_next, gy_next;
    logic v1, last1;
    logic [GRAD_W-1:0] sum;
`ifdef SOBEL_THRESH_EN
    localparam logic [GRAD_W-1:0] THR = GRAD_W'(THRESH);
`else
    localparam logic [GRAD_W-1:0] SAT = GRAD_W'(MAG_MAX);
`endif

    always_comb begin
        gx_next = (widen(nbr.r0[2]) + (widen(nbr.r1_c2) <<< 1) + widen(nbr.r2[2]))
                - (widen(nbr.r0[0]) + (widen(nbr.r1_c0) <<< 1) + widen(nbr.r2[0]));
        gy_next = (widen(nbr.r0[0]) + (widen(nbr.r0[1]) <<< 1) + widen(nbr.r0[2]))
                - (widen(nbr.r2[0]) + (widen(nbr.r2[1]) <<< 1) + widen(nbr.r2[2]));
        sum = (gx[GRAD_W-1] ? -gx : gx) + (gy[GRAD_W-1] ? -gy : gy);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gx <= '0;
            gy <= '0;
            v1 <= 1'b0;
            last1 <= 1'b0;
            mag <= '0;
            valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            v1 <= win_valid;
            last1 <= win_valid && win_last;
            if (win_valid) begin
                gx <= gx_next;
                gy <= gy_next;
            end
            valid <= v1;
            frame_done <= last1;
`ifdef SOBEL_THRESH_EN
            mag <= (sum >= THR) ? '1 : '0;
`else
            mag <= (sum > SAT) ? '1 : sum[PIX_W-1:0];
`endif
        end
    end
endmodule

// File: rtl/sobel_window_core.sv
// sobel_window_core: 3x3 window shift and row/col tracking feeding sobel_kernel.
// Optional SOBEL_THRESH_EN binarises the output against THRESH.
module sobel_window_core
    import sobel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int THRESH = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start_i,
    input  logic we_i,
    input  pix_t data0_i,
    input  pix_t data1_i,
    input  pix_t data2_i,
    output pix_t mag_o,
    output logic valid_o,
    output logic frame_done_o
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] col, cur_col, col_next;
    logic [RW-1:0] row, cur_row, row_next;
    logic completes, last_pix, win_valid, win_last;
    win_t win;
    nbr_t nbr;

    // A frame_start coinciding with a write makes that pixel (0,0).
    always_comb begin
        cur_col = frame_start_i ? '0 : col;
        cur_row = frame_start_i ? '0 : row;
        col_next = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
        row_next = (cur_col != COL_LAST || cur_row == ROW_LAST) ? cur_row : cur_row + 1'b1;
        completes = we_i && cur_col >= CW'(2) && cur_row >= RW'(2);
        last_pix = cur_col == COL_LAST && cur_row == ROW_LAST;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
            win <= '0;
            win_valid <= 1'b0;
            win_last <= 1'b0;
        end else begin
            win_valid <= completes;
            win_last <= last_pix;
            if (we_i) begin
                col <= col_next;
                row <= row_next;
                win <= {{data2_i, win[2][2:1]}, {data1_i, win[1][2:1]}, {data0_i, win[0][2:1]}};
            end else if (frame_start_i) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    assign nbr = '{r0: win[0], r2: win[2], r1_c0: win[1][0], r1_c2: win[1][2]};

    sobel_kernel #(.THRESH(THRESH)) u_kernel (
        .clk(clk),
        .rst(rst),
        .win_valid(win_valid),
        .win_last(win_last),
        .nbr(nbr),
        .mag(mag_o),
        .valid(valid_o),
        .frame_done(frame_done_o)
    );
endmodule

// File: tb/tb_sobel_window_core.sv
// tb_sobel_window_core: scoreboard bench on an 8x4 frame; expectations come from
// a reference Sobel model over the bench's own image array.
module tb_sobel_window_core;
    localparam int W = 8;
    localparam int H = 4;
    localparam int TH = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_start = 1'b0;
    logic we = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [7:0] mag;
    logic valid, fd;

    typedef struct {
        logic [7:0] mag;
        bit last;
        int edge_n;
    } exp_t;

    exp_t q[$];
    int img [H][W];
    int edges = 0;
    int n_checks = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_fd = 0;

    sobel_window_core #(.WIDTH(W), .HEIGHT(H), .THRESH(TH)) dut (
        .clk(clk),
        .rst(rst),
        .frame_start_i(frame_start),
        .we_i(we),
        .data0_i(d0),
        .data1_i(d1),
        .data2_i(d2),
        .mag_o(mag),
        .valid_o(valid),
        .frame_done_o(fd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    function automatic logic [7:0] exp_mag(input int r, input int c);
        int gx, gy, s;
        gx = (img[r][c] + 2*img[r-1][c] + img[r-2][c]) - (img[r][c-2] + 2*img[r-1][c-2] + img[r-2][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        return (s >= TH) ? 8'hFF : 8'h00;
`else
        return (s > 255) ? 8'hFF : 8'(s);
`endif
    endfunction

    task automatic fill(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (pat == 0) ? 100 : (pat == 1) ? (c < 4 ? 0 : 255) :
                            (pat == 2) ? 10*c : int'($urandom_range(0, 255));
    endtask

    // Drives n pixels from (0,0); starts and ends 1 ns after a rising edge.
    task automatic drive(input int gap, input bit fs_with, input int n);
        for (int k = 0; k < n; k++) begin
            int c, r;
            c = k % W;
            r = k / W;
            d0 = 8'(img[r][c]);
            d1 = (r >= 1) ? 8'(img[r-1][c]) : 8'h00;
            d2 = (r >= 2) ? 8'(img[r-2][c]) : 8'h00;
            we = 1'b1;
            frame_start = fs_with && k == 0;
            if (c >= 2 && r >= 2)
                q.push_back('{mag: exp_mag(r, c), last: (c == W-1 && r == H-1), edge_n: edges + 1});
            @(posedge clk); #1;
            we = 1'b0;
            frame_start = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        n_checks += 3;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        if (mag !== 8'h00) begin n_fail++; $display("FAIL reset_mag: got %h want 00", mag); end
        if (fd !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", fd); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame(input string name, input int pat, input int gap, input bit sep_fs);
        int v0, f0;
        v0 = n_valid;
        f0 = n_fd;
        fill(pat);
        if (sep_fs) pulse_fs();
        drive(gap, !sep_fs, W*H);
        settle();
        n_checks += 3;
        if (n_valid - v0 !== (W-2)*(H-2)) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", name, n_valid - v0, (W-2)*(H-2)); end
        if (n_fd - f0 !== 1) begin n_fail++; $display("FAIL %s_done: got %0d want 1", name, n_fd - f0); end
        if (q.size() !== 0) begin n_fail++; $display("FAIL %s_missing: got %0d pending want 0", name, q.size()); end
    endtask

    task automatic test_restart();
        int v0, f0;
        v0 = n_valid;
        f0 = n_fd;
        fill(2);
        drive(0, 1'b1, 2*W + 5);
        drive(0, 1'b1, W*H);
        settle();
        n_checks += 3;
        if (n_valid - v0 !== 3 + (W-2)*(H-2)) begin n_fail++; $display("FAIL restart_count: got %0d want %0d", n_valid - v0, 3 + (W-2)*(H-2)); end
        if (n_fd - f0 !== 1) begin n_fail++; $display("FAIL restart_done: got %0d want 1", n_fd - f0); end
        if (q.size() !== 0) begin n_fail++; $display("FAIL restart_missing: got %0d pending want 0", q.size()); end
    endtask

    task automatic test_async_reset();
        int v0, f0;
        logic [7:0] m;
        v0 = n_valid;
        f0 = n_fd;
        fill(2);
        m = exp_mag(2, 2);
        drive(0, 1'b1, 2*W + 4);
        #11;
        n_checks += 2;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL prereset_valid: got %b want 1", valid); end
        if (mag !== m) begin n_fail++; $display("FAIL prereset_mag: got %h want %h", mag, m); end
        rst = 1'b0;
        #1;
        n_checks += 3;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", valid); end
        if (mag !== 8'h00) begin n_fail++; $display("FAIL areset_mag: got %h want 00", mag); end
        if (fd !== 1'b0) begin n_fail++; $display("FAIL areset_fd: got %b want 0", fd); end
        q.delete();
        #3 rst = 1'b1;
        @(posedge clk); #1;
        pulse_fs();
        drive(0, 1'b0, W*H);
        settle();
        n_checks += 3;
        if (n_valid - v0 !== (W-2)*(H-2)) begin n_fail++; $display("FAIL areset_count: got %0d want %0d", n_valid - v0, (W-2)*(H-2)); end
        if (n_fd - f0 !== 1) begin n_fail++; $display("FAIL areset_done: got %0d want 1", n_fd - f0); end
        if (q.size() !== 0) begin n_fail++; $display("FAIL areset_missing: got %0d pending want 0", q.size()); end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (valid !== 1'b1) begin
                    n_checks++;
                    if (fd !== 1'b0) begin n_fail++; $display("FAIL stray_done: frame_done_o=%b with valid_o=%b", fd, valid); end
                end else begin
                    exp_t e;
                    n_valid++;
                    if (fd === 1'b1) n_fd++;
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_valid: valid_o=1 at edge %0d with no result expected", edges);
                    end else begin
                        e = q.pop_front();
                        n_checks += 2;
                        if (mag !== e.mag) begin n_fail++; $display("FAIL result_mag: got %h want %h", mag, e.mag); end
                        if (fd !== e.last) begin n_fail++; $display("FAIL result_done: got %b want %b", fd, e.last); end
                        if (edges !== e.edge_n + 2) begin n_fail++; $display("FAIL result_latency: got edge %0d want %0d", edges, e.edge_n + 2); end
                    end
                end
            end
        join_none
        test_reset();
        test_frame("uniform", 0, 0, 1'b1);
        test_frame("step", 1, 0, 1'b0);
        test_frame("ramp", 2, 0, 1'b0);
        test_frame("random", 3, 0, 1'b1);
        test_frame("gapped", 2, 2, 1'b0);
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_window_core.md
Name: sobel_window_core

Overview:
- Consumes the three row taps produced by the two-line FIFO buffer (current row, 1-row delay, 2-row delay), one pixel per write strobe.
- Builds a 3x3 window from the taps, computes the Sobel Gx/Gy gradients and the saturated 8-bit magnitude |Gx|+|Gy|.
- Emits one result per interior pixel with a valid strobe; image borders are dropped.
- Sits directly downstream of the line buffer and upstream of the result writer/display path.

Parameters:
- WIDTH, 640: pixels per row; must match the line-buffer DEPTH.
- HEIGHT, 480: rows per frame.
- THRESH, 128: binarisation threshold; used only with SOBEL_THRESH_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- frame_start_i  input  1  synchronous clear of the row/col counters; pulse before the first pixel of a frame.
- we_i  input  1  pixel strobe, same strobe that drives the line-buffer write.
- data0_i  input  8  current-row tap (newest row).
- data1_i  input  8  1-row-delayed tap.
- data2_i  input  8  2-row-delayed tap (oldest row).
- mag_o  output  8  gradient magnitude, saturated.
- valid_o  output  1  mag_o qualifier, single-cycle per result.
- frame_done_o  output  1  one-cycle pulse with the last result of a frame.

Behaviour:
- Reset (rst low, async): window regs, counters, pipeline regs cleared; mag_o=0, valid_o=0, frame_done_o=0.
- Window w[r][c]:
  - r=0 comes from data0_i, r=2 from data2_i; c=2 is the newest column.
  - On each we_i: each row shifts c0<=c1, c1<=c2, c2<=tap. No we_i: window holds.
- Counters:
  - col 0..WIDTH-1 is the column of the pixel being written. On we_i, col wraps to 0 at WIDTH-1 and row increments.
  - row saturates at HEIGHT-1 until frame_start_i.
  - frame_start_i clears col and row. If it coincides with we_i, the clear wins and that pixel is taken as col=0,row=0.
- Window valid (win_v):
  - Set on the we_i cycle where col>=2 and row>=2, registered with the shift.
  - The center pixel is (col-1,row-1).
  - Results per frame = (WIDTH-2)*(HEIGHT-2).
- Stage 1, registered on win_v:
  - Gx = (w02+2w12+w22)-(w00+2w10+w20).
  - Gy = (w00+2w01+w02)-(w20+2w21+w22).
  - Both signed 11-bit, range +/-1020, no overflow.
- Stage 2, registered:
  - s = |Gx|+|Gy|, unsigned 11-bit, max 2040.
  - mag_o = (s>255) ? 255 : s[7:0].
- Latency: valid_o asserts exactly 2 clk after the we_i edge that completes a window. This is fixed and independent of we_i gaps, since stages 1-2 advance every clock.
- frame_done_o: travels with the result whose window completed at col=WIDTH-1,row=HEIGHT-1.
- frame_start_i mid-frame: results already in stages 1-2 still emit; no new window until row>=2 again.
- Reset mid-frame: in-flight results are discarded with no valid_o.
- No back-pressure; the consumer must accept every valid_o.

Optional Feature:
- Macro SOBEL_THRESH_EN.
- Defined: stage 2 output is mag_o = (s >= THRESH) ? 8'hFF : 8'h00. Latency unchanged.
- Undefined: saturated magnitude as above; THRESH is unused.

Decomposition:
- Shared package sobel_pkg holds:
  - PIX_W=8, GRAD_W=11, MAG_MAX=255.
  - The signed gradient typedef.
  - The default WIDTH/HEIGHT, shared with the line-buffer DEPTH.
- One sub-module, sobel_kernel: purely the 3x3 to Gx/Gy/magnitude pipeline (stages 1-2 plus the valid pipe).
- Window shift and counters stay in the top.

Test Plan:
- Uniform frame: WIDTH=8,HEIGHT=4, all pixels 100, continuous we_i -> exactly 12 valid_o pulses, all mag_o=0; frame_done_o coincides with the 12th.
- Vertical step edge: pixels 0 for col<4, 255 for col>=4 (8x4) -> results centred at col 3,4 give Gx=1020, mag_o=255; all other results mag_o=0.
- Horizontal ramp: pixel=10*col -> every result mag_o=80 (Gx=80, Gy=0).
- Gapped strobe: same ramp with we_i high one cycle in three -> identical result sequence; each valid_o exactly 2 clk after its completing we_i.
- Mid-frame restart: frame_start_i asserted with we_i at row 2, col 5 -> in-flight results still emit; the next valid_o appears only after 2 full rows plus 3 pixels.
- Async reset: rst low mid-row for less than 1 clk -> valid_o, mag_o, frame_done_o go to 0 immediately; frame restarts clean after frame_start_i.
- With SOBEL_THRESH_EN, THRESH=128: ramp -> all 0x00; step -> 0xFF at col 3,4.
